voice_allocator: RTL and testbench



---
 rtl/voice_allocator.sv | 252 +++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note events to NUM_VOICES sine-generator slots.
// Option VOICE_STEAL_EN: a note-on that finds no slot steals the oldest one.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   ev_valid/ready  event handshake
//   ev_on           1 = note-on, 0 = note-off
//   ev_note         MIDI note number
//   ev_velocity     velocity, becomes slot volume
//   ev_period       generator period for ev_note
//   voice_period    slot i at [23i+22:23i]
//   voice_volume    slot i at [7i+6:7i]
//   voice_active    gate per slot
//   voice_reset     one-cycle phase-reset pulse per slot
//   ev_dropped      one-cycle pulse when a note-on is discarded
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [6:0]                 ev_note,
  input  logic [6:0]                 ev_velocity,
  input  logic [22:0]                ev_period,
  output logic [NUM_VOICES*23-1:0]   voice_period,
  output logic [NUM_VOICES*7-1:0]    voice_volume,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic [NUM_VOICES-1:0]      voice_reset,
  output logic                       ev_dropped
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IW-1:0] idx_q;

  logic          lat_on;
  logic [6:0]    lat_note;
  logic [6:0]    lat_vel;
  logic [22:0]   lat_period;

  logic          match_f;
  logic [IW-1:0] match_i;
  logic          free_f;
  logic [IW-1:0] free_i;
`ifdef VOICE_STEAL_EN
  logic             old_f;
  logic [IW-1:0]    old_i;
  logic [AGE_W-1:0] old_age;
`endif

  logic [22:0]      period_q [NUM_VOICES];
  logic [6:0]       volume_q [NUM_VOICES];
  logic [6:0]       note_q   [NUM_VOICES];
  logic [AGE_W-1:0] age_q    [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q;
  logic [NUM_VOICES-1:0] pulse_q;

  logic [IW-1:0] tgt;
  logic          do_load;
  logic          do_clear;
`ifndef VOICE_STEAL_EN
  logic          do_drop;
  logic          drop_q;
`endif

  assign ev_ready = (state_q == IDLE) & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (ev_valid) state_d = SCAN;
      end
      SCAN: begin
        if (idx_q == LAST) state_d = WRITE;
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Event latch and one-slot-per-cycle search.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      lat_on     <= 1'b0;
      lat_note   <= '0;
      lat_vel    <= '0;
      lat_period <= '0;
      match_f    <= 1'b0;
      match_i    <= '0;
      free_f     <= 1'b0;
      free_i     <= '0;
`ifdef VOICE_STEAL_EN
      old_f      <= 1'b0;
      old_i      <= '0;
      old_age    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ev_valid) begin
            // velocity 0 note-on is a note-off
            lat_on     <= ev_on & (ev_velocity != 7'd0);
            lat_note   <= ev_note;
            lat_vel    <= ev_velocity;
            lat_period <= ev_period;
            idx_q      <= '0;
            match_f    <= 1'b0;
            free_f     <= 1'b0;
`ifdef VOICE_STEAL_EN
            old_f      <= 1'b0;
`endif
          end
        end
        SCAN: begin
          idx_q <= idx_q + 1'b1;
          if (!match_f && active_q[idx_q] &&
              note_q[idx_q] == lat_note) begin
            match_f <= 1'b1;
            match_i <= idx_q;
          end
          if (!free_f && !active_q[idx_q]) begin
            free_f <= 1'b1;
            free_i <= idx_q;
          end
`ifdef VOICE_STEAL_EN
          // strict > keeps the lowest index on ties
          if (active_q[idx_q] &&
              (!old_f || age_q[idx_q] > old_age)) begin
            old_f   <= 1'b1;
            old_i   <= idx_q;
            old_age <= age_q[idx_q];
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  // Target choice: match, else free, else oldest (or drop).
  always_comb begin
    tgt      = match_i;
    do_load  = 1'b0;
    do_clear = 1'b0;
`ifndef VOICE_STEAL_EN
    do_drop  = 1'b0;
`endif
    if (lat_on) begin
      if (match_f) begin
        do_load = 1'b1;
      end else if (free_f) begin
        tgt     = free_i;
        do_load = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        tgt     = old_i;
        do_load = old_f;
`else
        do_drop = 1'b1;
`endif
      end
    end else begin
      do_clear = match_f;
    end
  end

  // Slot registers only change in WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        period_q[i] <= '0;
        volume_q[i] <= '0;
        note_q[i]   <= '0;
        age_q[i]    <= '0;
      end
      active_q <= '0;
      pulse_q  <= '0;
`ifndef VOICE_STEAL_EN
      drop_q   <= 1'b0;
`endif
    end else begin
      pulse_q <= '0;
`ifndef VOICE_STEAL_EN
      drop_q  <= 1'b0;
`endif
      if (state_q == WRITE) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (do_load && IW'(i) == tgt) begin
            period_q[i] <= lat_period;
            volume_q[i] <= lat_vel;
            note_q[i]   <= lat_note;
            age_q[i]    <= '0;
            active_q[i] <= 1'b1;
            pulse_q[i]  <= 1'b1;
          end else if (do_load && active_q[i] &&
                       age_q[i] != '1) begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end
        if (do_clear) begin
          active_q[tgt] <= 1'b0;
          volume_q[tgt] <= '0;
        end
`ifndef VOICE_STEAL_EN
        drop_q <= do_drop;
`endif
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
    assign voice_period[23*g +: 23] = period_q[g];
    assign voice_volume[7*g +: 7]   = volume_q[g];
  end

  assign voice_active = active_q;
  assign voice_reset  = pulse_q;

`ifdef VOICE_STEAL_EN
  assign ev_dropped = 1'b0;
`else
  assign ev_dropped = drop_q;
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed events against an event-level slot model.
// Checks every cycle plus literal expectations per test step.
module tb_voice_allocator;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           ev_valid = 1'b0;
  logic           ev_ready;
  logic           ev_on = 1'b0;
  logic [6:0]     ev_note = '0;
  logic [6:0]     ev_velocity = '0;
  logic [22:0]    ev_period = '0;
  logic [N*23-1:0] voice_period;
  logic [N*7-1:0]  voice_volume;
  logic [N-1:0]    voice_active;
  logic [N-1:0]    voice_reset;
  logic            ev_dropped;

  voice_allocator #(
    .NUM_VOICES(N),
    .AGE_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_on(ev_on),
    .ev_note(ev_note),
    .ev_velocity(ev_velocity),
    .ev_period(ev_period),
    .voice_period(voice_period),
    .voice_volume(voice_volume),
    .voice_active(voice_active),
    .voice_reset(voice_reset),
    .ev_dropped(ev_dropped)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state (updated at handshake)
  bit          m_act  [N];
  logic [6:0]  m_note [N];
  logic [6:0]  m_vol  [N];
  logic [22:0] m_per  [N];
  int          m_age  [N];
  logic [N-1:0] p_rst;
  bit           p_drop;

  // expected DUT outputs (updated when results become visible)
  bit          e_act [N];
  logic [6:0]  e_vol [N];
  logic [22:0] e_per [N];
  logic [N-1:0] e_rst = '0;
  bit           e_drop = 1'b0;
  bit           busy = 1'b0;
  bit           chk_en = 1'b0;

  logic [N-1:0] cap_rst;
  bit           cap_drop;

  task automatic chk(input string nm,
                     input logic [127:0] got,
                     input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, got, want);
    end
  endtask

  always @(negedge clk) begin : cmp
    logic [N*23-1:0] ep;
    logic [N*7-1:0]  ev;
    logic [N-1:0]    ea;
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        ep[23*i +: 23] = e_per[i];
        ev[7*i +: 7]   = e_vol[i];
        ea[i]          = e_act[i];
      end
      chk("period", voice_period, ep);
      chk("volume", voice_volume, ev);
      chk("active", voice_active, ea);
      chk("vreset", voice_reset, e_rst);
      chk("dropped", ev_dropped, e_drop);
      chk("ready", ev_ready, !busy && !reset);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_vol[i] = 0;
      m_per[i] = 0; m_age[i] = 0;
      e_act[i] = 0; e_vol[i] = 0; e_per[i] = 0;
    end
    e_rst = '0;
    e_drop = 0;
    busy = 0;
  endtask

  // Event semantics: match, else free, else oldest (if stealing).
  task automatic model_event(input bit on, input logic [6:0] nt,
                             input logic [6:0] vel,
                             input logic [22:0] per);
    int m, f, o, t;
    bit is_on;
    m = -1; f = -1; o = -1; t = -1;
    is_on = on && (vel != 0);
    p_rst = '0;
    p_drop = 0;
    for (int i = 0; i < N; i++) begin
      if (m < 0 && m_act[i] && m_note[i] == nt) m = i;
      if (f < 0 && !m_act[i]) f = i;
      if (m_act[i] && (o < 0 || m_age[i] > m_age[o])) o = i;
    end
    if (is_on) begin
      if (m >= 0) t = m;
      else if (f >= 0) t = f;
`ifdef VOICE_STEAL_EN
      else t = o;
`endif
      if (t < 0) begin
        p_drop = 1;
      end else begin
        for (int i = 0; i < N; i++)
          if (i != t && m_act[i] && m_age[i] < AGE_MAX)
            m_age[i]++;
        m_act[t] = 1; m_note[t] = nt; m_vol[t] = vel;
        m_per[t] = per; m_age[t] = 0;
        p_rst[t] = 1'b1;
      end
    end else if (m >= 0) begin
      m_act[m] = 0;
      m_vol[m] = 0;
    end
  endtask

  task automatic send(input bit on, input logic [6:0] nt,
                      input logic [6:0] vel,
                      input logic [22:0] per);
    @(posedge clk); #1;
    ev_valid = 1; ev_on = on; ev_note = nt;
    ev_velocity = vel; ev_period = per;
    @(posedge clk);
    busy = 1;
    model_event(on, nt, vel, per);
    #1 ev_valid = 0;
    repeat (N) @(posedge clk);
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      e_act[i] = m_act[i];
      e_vol[i] = m_vol[i];
      e_per[i] = m_per[i];
    end
    e_rst = p_rst;
    e_drop = p_drop;
    busy = 0;
    @(negedge clk);
    cap_rst = voice_reset;
    cap_drop = ev_dropped;
    @(posedge clk); #1;
    e_rst = '0;
    e_drop = 0;
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    ev_valid = 1; ev_on = 1; ev_note = 7'd80;
    ev_velocity = 7'd50; ev_period = 23'd1234;
    @(posedge clk);
    busy = 1;
    #1 ev_valid = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk);
    model_reset();
    #1 reset = 0;
    @(negedge clk);
    chk("mid_active", voice_active, 4'b0000);
    chk("mid_ready", ev_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at %0t", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    @(posedge clk);
    chk_en = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", ev_ready, 1'b1);

    // basic allocation
    send(1, 7'd60, 7'd100, 23'd100000);
    chk("t1_vol0", voice_volume[6:0], 7'd100);
    chk("t1_per0", voice_period[22:0], 23'd100000);
    chk("t1_act", voice_active, 4'b0001);
    chk("t1_rst", cap_rst, 4'b0001);

    // fill and free
    send(1, 7'd62, 7'd80, 23'd90000);
    send(1, 7'd64, 7'd70, 23'd80000);
    send(1, 7'd65, 7'd60, 23'd75000);
    chk("t2_full", voice_active, 4'b1111);
    send(0, 7'd62, 7'd0, 23'd0);
    chk("t2_off", voice_active, 4'b1101);
    chk("t2_vol1", voice_volume[13:7], 7'd0);
    chk("t2_per1", voice_period[45:23], 23'd90000);
    send(1, 7'd67, 7'd50, 23'd70000);
    chk("t2_rst", cap_rst, 4'b0010);
    chk("t2_per1b", voice_period[45:23], 23'd70000);

    // retrigger
    send(1, 7'd60, 7'd20, 23'd100000);
    chk("t3_vol0", voice_volume[6:0], 7'd20);
    chk("t3_rst", cap_rst, 4'b0001);
    chk("t3_act", voice_active, 4'b1111);

    // velocity-0 note-off, absent note-off
    send(1, 7'd64, 7'd0, 23'd80000);
    chk("t4_act", voice_active, 4'b1011);
    chk("t4_rst", cap_rst, 4'b0000);
    chk("t4_per2", voice_period[68:46], 23'd80000);
    send(0, 7'd70, 7'd0, 23'd0);
    chk("t4_drop", cap_drop, 1'b0);
    chk("t4_act2", voice_active, 4'b1011);

    // reset mid-operation, then normal acceptance
    reset_mid();
    send(1, 7'd60, 7'd100, 23'd100000);
    chk("t6_rst", cap_rst, 4'b0001);
    send(1, 7'd62, 7'd80, 23'd90000);
    send(1, 7'd64, 7'd70, 23'd80000);
    send(1, 7'd65, 7'd60, 23'd75000);

    // full, fifth note
    send(1, 7'd72, 7'd90, 23'd60000);
`ifdef VOICE_STEAL_EN
    chk("t5_rst", cap_rst, 4'b0001);
    chk("t5_vol0", voice_volume[6:0], 7'd90);
    chk("t5_per0", voice_period[22:0], 23'd60000);
    chk("t5_drop", cap_drop, 1'b0);
`else
    chk("t5_rst", cap_rst, 4'b0000);
    chk("t5_drop", cap_drop, 1'b1);
    chk("t5_vol0", voice_volume[6:0], 7'd100);
    chk("t5_per0", voice_period[22:0], 23'd100000);
`endif
    chk("t5_act", voice_active, 4'b1111);

    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
